dmem_arbiter: RTL

//  Shares the single-port data memory between the CPU load/store port and an external

---
 rtl/dmem_arb_pkg.sv | 17 +
 rtl/dmem_arb_stats.sv | 36 +++
 rtl/dmem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: ownership states and port ids.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OWN_CPU = 2'd1,
    ST_OWN_EXT = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  function automatic logic owns_port(input arb_state_t st);
    return (st == ST_OWN_CPU) || (st == ST_OWN_EXT);
  endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating grant/conflict counters for dmem_arbiter; present only when
// DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cpu_ack,
  input  logic             i_ext_ack,
  input  logic             i_conflict,
  output logic [CNT_W-1:0] o_cpu_grants,
  output logic [CNT_W-1:0] o_ext_grants,
  output logic [CNT_W-1:0] o_conflict
);

  logic [CNT_W-1:0] r_cpu_grants;
  logic [CNT_W-1:0] r_ext_grants;
  logic [CNT_W-1:0] r_conflict;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cpu_grants <= '0;
      r_ext_grants <= '0;
      r_conflict   <= '0;
    end else begin
      if (i_cpu_ack && !(&r_cpu_grants)) r_cpu_grants <= r_cpu_grants + 1'b1;
      if (i_ext_ack && !(&r_ext_grants)) r_ext_grants <= r_ext_grants + 1'b1;
      if (i_conflict && !(&r_conflict))  r_conflict   <= r_conflict + 1'b1;
    end
  end

  assign o_cpu_grants = r_cpu_grants;
  assign o_ext_grants = r_ext_grants;
  assign o_conflict   = r_conflict;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: CPU has fixed priority, ext gets a starvation
// guard and burst lock. Optional statistics under DMEM_ARB_STATS_EN.
//
// state      | meaning
// ST_IDLE    | nobody owns the memory, outputs parked at zero
// ST_OWN_CPU | CPU port drives the memory, acked while cpu_req held
// ST_OWN_EXT | ext port drives the memory, may be held with ext_lock
import dmem_arb_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wd,
  output logic [DATA_W-1:0] o_cpu_rd,
  output logic              o_cpu_ack,
  input  logic              i_ext_req,
  input  logic              i_ext_lock,
  input  logic              i_ext_we,
  input  logic [ADDR_W-1:0] i_ext_addr,
  input  logic [DATA_W-1:0] i_ext_wd,
  output logic [DATA_W-1:0] o_ext_rd,
  output logic              o_ext_ack,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wd,
  input  logic [DATA_W-1:0] i_mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  o_stat_cpu_grants,
  output logic [CNT_W-1:0]  o_stat_ext_grants,
  output logic [CNT_W-1:0]  o_stat_conflict
`endif
);

  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] STARVE_LIM = WAIT_W'(STARVE_MAX);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_state_t        w_pick;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              w_starved;
  logic              w_cpu_ack;
  logic              w_ext_ack;
  logic              w_sel_port;
  logic              w_owned;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ext_ack)
        r_wait_cnt <= '0;
      else if (i_ext_req && (r_wait_cnt != STARVE_LIM))
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign w_starved = (r_wait_cnt == STARVE_LIM) && (r_state != ST_OWN_EXT);

  always_comb begin
    w_pick      = ST_IDLE;
    w_state_nxt = ST_IDLE;
    if (i_ext_req && (w_starved || !i_cpu_req))
      w_pick = ST_OWN_EXT;
    else if (i_cpu_req)
      w_pick = ST_OWN_CPU;
    // A locked burst holds ext ownership regardless of CPU priority.
    if ((r_state == ST_OWN_EXT) && i_ext_lock && i_ext_req)
      w_state_nxt = ST_OWN_EXT;
    else
      w_state_nxt = w_pick;
  end

  // Reset gates the acks so a write in flight when reset hits never commits.
  assign w_cpu_ack = i_reset && (r_state == ST_OWN_CPU) && i_cpu_req;
  assign w_ext_ack = i_reset && (r_state == ST_OWN_EXT) && i_ext_req;

  assign w_owned    = owns_port(r_state);
  assign w_sel_port = (r_state == ST_OWN_EXT) ? PORT_EXT : PORT_CPU;

  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_wd   = '0;
    if (w_owned) begin
      if (w_sel_port == PORT_EXT) begin
        o_mem_we   = i_ext_we & w_ext_ack;
        o_mem_addr = i_ext_addr;
        o_mem_wd   = i_ext_wd;
      end else begin
        o_mem_we   = i_cpu_we & w_cpu_ack;
        o_mem_addr = i_cpu_addr;
        o_mem_wd   = i_cpu_wd;
      end
    end
  end

  assign o_cpu_ack = w_cpu_ack;
  assign o_ext_ack = w_ext_ack;
  assign o_cpu_rd  = i_mem_rd;
  assign o_ext_rd  = i_mem_rd;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_cpu_ack    (w_cpu_ack),
    .i_ext_ack    (w_ext_ack),
    .i_conflict   (i_cpu_req && i_ext_req),
    .o_cpu_grants (o_stat_cpu_grants),
    .o_ext_grants (o_stat_ext_grants),
    .o_conflict   (o_stat_conflict)
  );
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule
